// File: rtl/cpu_clock_controller.sv
// Clock-enable sequencer for the single-cycle CPU: programmable divider (free-run),
// debounced single-step, and halt/resume handling. Emits one-cycle cpuEnable pulses.
module cpu_clock_controller #(
  parameter int COUNTER_WIDTH  = 32,
  parameter int DEFAULT_DIVIDE = 10,
  parameter int DEBOUNCE       = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     runSwitch,
  input  logic                     stepButton,
  input  logic                     haltRequest,
  input  logic                     resume,
  input  logic [COUNTER_WIDTH-1:0] divide,
  input  logic                     loadDivide,
  output logic                     cpuEnable,
  output logic                     halted,
  output logic [1:0]               state,
  output logic [COUNTER_WIDTH-1:0] enableCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_e;

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam logic [COUNTER_WIDTH-1:0] DEF_DIV = COUNTER_WIDTH'(DEFAULT_DIVIDE);
  localparam logic [COUNTER_WIDTH-1:0] ONE     = COUNTER_WIDTH'(1);
  localparam logic [DB_W-1:0]          DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [DB_W-1:0]          DB_ONE  = DB_W'(1);

  state_e                     state_q, state_d;
  logic [COUNTER_WIDTH-1:0]   counter_q, counter_d;
  logic [COUNTER_WIDTH-1:0]   divide_reg_q, divide_reg_d;
  logic [COUNTER_WIDTH-1:0]   pending_q, pending_d;
  logic [COUNTER_WIDTH-1:0]   count_q;
  logic                       enable_q;
  logic                       pulse;
  logic                       sync1_q, sync2_q;
  logic [DB_W-1:0]            db_cnt_q;
  logic                       db_level_q, db_prev_q;
  logic                       resume_prev_q;
  logic                       db_rise, resume_rise, wrap;

  assign db_rise     = db_level_q & ~db_prev_q;
  assign resume_rise = resume & ~resume_prev_q;
  // Ratios of 0 and 1 both collapse to a pulse every cycle.
  assign wrap        = (divide_reg_q <= ONE) || (counter_q == divide_reg_q - ONE);

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    divide_reg_d = pending_q;
    pending_d    = loadDivide ? divide : pending_q;
    pulse        = 1'b0;
    unique case (state_q)
      IDLE: begin
        counter_d = '0;
        state_d   = runSwitch ? RUN : STEP;
      end
      RUN: begin
        // Outside RUN the ratio tracks pendingDivide; inside it only changes at wrap.
        divide_reg_d = divide_reg_q;
        if (haltRequest) begin
          state_d   = HALTED;
          counter_d = '0;
        end else if (!runSwitch) begin
          state_d   = STEP;
          counter_d = '0;
        end else if (wrap) begin
          pulse        = 1'b1;
          counter_d    = '0;
          divide_reg_d = pending_q;
        end else begin
          counter_d = counter_q + ONE;
        end
      end
      STEP: begin
        counter_d = '0;
        if (haltRequest)    state_d = HALTED;
        else if (runSwitch) state_d = RUN;
        else                pulse   = db_rise;
      end
      HALTED: begin
        counter_d = '0;
        if (resume_rise && !haltRequest) state_d = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      divide_reg_q <= DEF_DIV;
      pending_q    <= DEF_DIV;
      enable_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      divide_reg_q <= divide_reg_d;
      pending_q    <= pending_d;
      enable_q     <= pulse;
      if (pulse) count_q <= count_q + ONE;
    end
  end

  // Button synchronizer and stability filter; any bounce restarts the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      db_cnt_q      <= '0;
      db_level_q    <= 1'b0;
      db_prev_q     <= 1'b0;
      resume_prev_q <= 1'b0;
    end else begin
      sync1_q       <= stepButton;
      sync2_q       <= sync1_q;
      db_prev_q     <= db_level_q;
      resume_prev_q <= resume;
      if (sync2_q == db_level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_level_q <= sync2_q;
        db_cnt_q   <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DB_ONE;
      end
    end
  end

  assign cpuEnable   = enable_q;
  assign halted      = (state_q == HALTED);
  assign state       = state_q;
  assign enableCount = count_q;

endmodule

// File: doc/cpu_clock_controller.md
Name: cpu_clock_controller

Overview:
- Sequences CPU execution on the FPGA board by issuing a one-cycle clock-enable pulse (`cpuEnable`) that the single-cycle CPU datapath and register file qualify on.
- Contains its own programmable divider with glitch-free ratio changes.
- Supports three run modes: free-run at the divided rate, single-step from a debounced push button, and halt on CPU request with resume.

Parameters:
- COUNTER_WIDTH, 32: width of the divider counter, the `divide` input and the `enableCount` output.
- DEFAULT_DIVIDE, 10: divide ratio loaded at reset.
- DEBOUNCE, 16: consecutive stable cycles required before the synchronized `stepButton` level is accepted.

Ports:
- `clock` in 1: system clock; all logic rising-edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state immediately.
- `runSwitch` in 1: level; 1 = free-run mode, 0 = single-step mode.
- `stepButton` in 1: raw asynchronous push button, active-high.
- `haltRequest` in 1: level from CPU (halt syscall); synchronous to `clock`.
- `resume` in 1: level; its rising edge leaves HALTED.
- `divide` in COUNTER_WIDTH: new divide ratio.
- `loadDivide` in 1: 1-cycle strobe; captures `divide` into pendingDivide.
- `cpuEnable` out 1: one-cycle enable pulse, registered.
- `halted` out 1: 1 while in HALTED.
- `state` out 2: IDLE=0, RUN=1, STEP=2, HALTED=3.
- `enableCount` out COUNTER_WIDTH: number of pulses issued, wraps modulo 2^COUNTER_WIDTH.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - outputs: `cpuEnable`=0, `halted`=0, `state`=IDLE, `enableCount`=0.
  - internal: counter=0, divideReg=pendingDivide=DEFAULT_DIVIDE; synchronizers, debounce counter and debounced level=0; resume edge-detect flop=0.
  - Reset mid-pulse or mid-debounce aborts with no further pulse.
- Ratio rule: an effective ratio of 0 or 1 means a pulse every cycle.
- `loadDivide`:
  - writes pendingDivide.
  - In RUN, divideReg takes pendingDivide only at counter wrap, so the current period always completes at the old ratio.
  - In any other state, divideReg takes pendingDivide on the next cycle.
- IDLE: one cycle, no pulse. Next state is RUN if `runSwitch`=1, else STEP. Counter is cleared.
- RUN:
  - Counter increments each cycle.
  - When counter == divideReg-1: `cpuEnable`=1 on the next clock edge, counter→0, pendingDivide applied.
  - First pulse is registered on the D-th rising edge after entering RUN, with D = divideReg.
  - `runSwitch`=0 → STEP, counter cleared, no pulse that cycle.
- STEP:
  - A debounced rising edge of `stepButton` gives exactly one `cpuEnable` pulse, registered one cycle after the debounced level rises.
  - Holding the button gives no repeat.
  - `runSwitch`=1 → RUN with counter=0.
- Debounce path:
  - 2-flop synchronizer on `stepButton`, then a stability counter.
  - The debounced level follows the synchronized level only after DEBOUNCE consecutive cycles of disagreement.
  - Shorter glitches are discarded and the counter restarts on any bounce.
  - The debounced level is tracked in all states; edges produce pulses only in STEP.
- HALTED:
  - Entered from RUN or STEP when `haltRequest`=1.
  - `haltRequest` wins over a coincident wrap or step pulse: that pulse is suppressed.
  - `halted`=1 from the cycle after the request is sampled.
  - No pulses while halted. Counter is held at 0.
  - Rising edge of `resume` (edge-detected against the previous sample) → IDLE, but only if `haltRequest`=0 that cycle; otherwise stay HALTED.
  - `resume` held high across entry to HALTED does not count as an edge.
- Priority in each cycle: reset > haltRequest > runSwitch mode change > pulse generation.
- `enableCount` increments in the same cycle `cpuEnable` is 1.

Test Plan:
- Reset release, `runSwitch`=1, default ratio 10 → IDLE one cycle, then `cpuEnable` pulses every 10 cycles; `enableCount`=5 after 5 pulses; `reset` low mid-period → outputs 0 immediately.
- In RUN with ratio 10, strobe `loadDivide` with `divide`=4 at counter=3 → the current period still ends at 10 cycles, then pulses every 4; `divide`=0 → a pulse every cycle.
- `runSwitch`=0, `stepButton` bounces (3 cycles high, 2 low) then held 40 cycles with DEBOUNCE=16 → exactly one pulse about 19 cycles after the stable rise; no repeat while held.
- RUN, `haltRequest` asserted on the wrap cycle → no pulse, `halted`=1 next cycle, `state`=3; `resume` rising edge while `haltRequest`=0 → IDLE, then RUN with first pulse D cycles later.
- HALTED with `resume` and `haltRequest` rising together → remain HALTED; `resume` held high through halt entry → no exit until it toggles low then high.
